// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a weight-stationary systolic array: loads cfg_k weight rows,
// then streams cfg_len input vectors with diagonal row/column enable skew.
module systolic_seq_ctrl #(
    parameter int unsigned ROWS = 32,
    parameter int unsigned COLS = 32,
    parameter int unsigned KW   = 5,
    parameter int unsigned LW   = 8
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic            abort,
    input  logic            stall,
    input  logic [KW-1:0]   cfg_k,
    input  logic [LW-1:0]   cfg_len,
    output logic            w_ps,
    output logic            w_load_en,
    output logic [ROWS-1:0] input_en,
    output logic [COLS-1:0] out_en,
    output logic            busy,
    output logic            done
);

    localparam int unsigned TW = $clog2(ROWS + COLS + 2**LW);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DONE} state_t;

    state_t         state;
    logic [KW-1:0]  k_lat;
    logic [KW-1:0]  load_cnt;
    logic [LW-1:0]  len_lat;
    logic [TW-1:0]  t;
    logic [TW-1:0]  t_next;
    logic [TW-1:0]  t_last;

    // Last schedule step of the stream phase: T-1 = ROWS+COLS-2+len.
    assign t_last = TW'(ROWS + COLS - 2) + TW'(len_lat);
    assign t_next = t + TW'(1);

    function automatic logic [ROWS-1:0] in_dec(input logic [TW-1:0] tt,
                                               input logic [LW-1:0] len);
        logic [ROWS-1:0] v;
        v = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            v[r] = (tt >= TW'(r)) && (tt < TW'(r) + TW'(len));
        end
        return v;
    endfunction

    function automatic logic [COLS-1:0] out_dec(input logic [TW-1:0] tt,
                                                input logic [LW-1:0] len);
        logic [COLS-1:0] v;
        v = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            v[c] = (tt >= TW'(ROWS + c)) && (tt < TW'(ROWS + c) + TW'(len));
        end
        return v;
    endfunction

    // Enables are registered as the decode of the step shown in the next cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            k_lat     <= '0;
            len_lat   <= '0;
            load_cnt  <= '0;
            t         <= '0;
            w_ps      <= 1'b0;
            w_load_en <= 1'b0;
            input_en  <= '0;
            out_en    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            w_ps      <= 1'b0;
            w_load_en <= 1'b0;
            input_en  <= '0;
            out_en    <= '0;
            done      <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                k_lat    <= '0;
                len_lat  <= '0;
                load_cnt <= '0;
                t        <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            k_lat   <= cfg_k;
                            len_lat <= cfg_len;
                            busy    <= 1'b1;
                            t       <= '0;
                            if (cfg_k == '0 || cfg_len == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= LOAD_W;
                                load_cnt  <= KW'(1);
                                w_ps      <= 1'b1;
                                w_load_en <= 1'b1;
                            end
                        end
                    end
                    LOAD_W: begin
                        if (load_cnt == k_lat) begin
                            state    <= STREAM;
                            t        <= '0;
                            input_en <= in_dec('0, len_lat);
                            out_en   <= out_dec('0, len_lat);
                        end else begin
                            load_cnt  <= load_cnt + KW'(1);
                            w_ps      <= 1'b1;
                            w_load_en <= 1'b1;
                        end
                    end
                    STREAM: begin
                        // A stalled edge leaves t on the step already shown.
                        if (!stall) begin
                            if (t == t_last) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                t        <= t_next;
                                input_en <= in_dec(t_next, len_lat);
                                out_en   <= out_dec(t_next, len_lat);
                            end
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        k_lat    <= '0;
                        len_lat  <= '0;
                        load_cnt <= '0;
                        t        <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/systolic_seq_ctrl.md
SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 32: systolic array rows, each row's input enable is one bit.
REQ-002 The block SHALL have parameter COLS, default 32: systolic array columns, each column's output enable is one bit.
REQ-003 The block SHALL have parameter KW, default 5: width of cfg_k.
REQ-004 The block SHALL have parameter LW, default 8: width of cfg_len.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 The block SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port start, input, 1 bit: begin one convolution pass; sampled in IDLE only.
REQ-008 The block SHALL have port abort, input, 1 bit: synchronous cancel of the current pass.
REQ-009 The block SHALL have port stall, input, 1 bit: freeze the streaming schedule.
REQ-010 The block SHALL have port cfg_k, input, KW bits: weight rows to load.
REQ-011 The block SHALL have port cfg_len, input, LW bits: input vectors per pass.
REQ-012 The block SHALL have port w_ps, output, 1 bit: 1 = array in weight-load mode, 0 = partial-sum mode.
REQ-013 The block SHALL have port w_load_en, output, 1 bit: shift one weight row into the array.
REQ-014 The block SHALL have port input_en, output, ROWS bits: per-row input-valid enable.
REQ-015 The block SHALL have port out_en, output, COLS bits: per-column output-capture enable.
REQ-016 The block SHALL have port busy, output, 1 bit: pass in progress (state not IDLE).
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse at pass completion.

Function
REQ-018 States SHALL be IDLE, LOAD_W, STREAM and DONE; all outputs SHALL be registered or decoded from registered state and counters only.
REQ-019 In IDLE with start=1 and abort=0, cfg_k and cfg_len SHALL be latched, with the next state LOAD_W, or DONE if either value is 0.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 In LOAD_W, w_ps and w_load_en SHALL be 1 for exactly cfg_k consecutive cycles, with no stall effect, followed by STREAM.
REQ-022 In STREAM, w_ps SHALL be 0.
REQ-023 In STREAM, schedule counter t SHALL start at 0 and be sized clog2(ROWS+COLS+2^LW) bits with no overflow.
REQ-024 In STREAM, input_en[r] SHALL be 1 iff r <= t < r+cfg_len (diagonal skew).
REQ-025 In STREAM, out_en[c] SHALL be 1 iff ROWS+c <= t < ROWS+c+cfg_len.
REQ-026 The STREAM length SHALL be T = ROWS+COLS-1+cfg_len non-stalled cycles, with t running 0..T-1, then DONE.
REQ-027 In STREAM with stall=1, t SHALL hold, and input_en and out_en SHALL be all 0 that cycle; the schedule SHALL resume unchanged when stall=0.
REQ-028 stall SHALL have no effect outside STREAM.
REQ-029 DONE SHALL last 1 cycle with done=1 and busy=1, then return to IDLE.
REQ-030 abort=1 in any state SHALL force IDLE on the next edge, with all enables 0 from that edge, no done pulse, and latched config discarded.
REQ-031 When abort and start are both 1 in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-032 In IDLE, w_ps, w_load_en, input_en, out_en, busy and done SHALL all be 0.

Reset
REQ-033 On nrst=0, asynchronously: state SHALL be IDLE, t and the load counter 0, latched config 0, and all outputs 0.
REQ-034 Reset mid-pass SHALL abandon the pass without a done pulse.
REQ-035 After reset release, the first start SHALL be honoured on the first rising edge.

Verification (ROWS=COLS=4, KW=3, LW=4)
REQ-036 The bench SHALL cover reset: assert nrst=0 mid-STREAM -> all outputs 0 immediately, busy=0, no done.
REQ-037 The bench SHALL cover a basic pass: start with cfg_k=3, cfg_len=2.
  - w_ps=w_load_en=1 for 3 cycles.
  - input_en[0] at t=0,1 and input_en[3] at t=3,4.
  - out_en[0] at t=4,5 and out_en[3] at t=7,8.
  - T=9, then done=1 for 1 cycle.
REQ-038 The bench SHALL cover stall: same configuration, stall=1 at t=2 for 2 cycles -> enables 0 those cycles, t holds at 2, done 2 cycles later than in REQ-037.
REQ-039 The bench SHALL cover abort: abort at t=5 -> next cycle IDLE, all 0, no done; a new start then runs a full pass correctly.
REQ-040 The bench SHALL cover the degenerate case: start with cfg_len=0 -> DONE next cycle, done pulse, no w_load_en, input_en or out_en activity.
REQ-041 The bench SHALL cover the start rules.
  - start pulses during LOAD_W or STREAM are ignored, and the pass timing is unchanged.
  - start+abort together in IDLE gives busy=0.
